// File: rtl/sd_sector_responder.sv
// sd_sector_responder: RAM-disk responder for the virtual-disk sector bus.
// Optional macro SDRESP_BURST_EN: one 64-beat burst read per sector.

module sd_sector_responder #(
  parameter int          VDNUM       = 3,
  parameter logic [31:0] IMG_BASE    = 32'h30000000,
  parameter logic [31:0] IMG_STRIDE  = 32'h04000000,
  parameter int          IMG_SECTORS = 131072
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [32*VDNUM-1:0] sd_lba,
  input  logic [VDNUM-1:0]    sd_rd,
  input  logic [VDNUM-1:0]    sd_wr,
  output logic [VDNUM-1:0]    sd_ack,
  output logic [7:0]          sd_buff_addr,
  output logic [15:0]         sd_buff_dout,
  input  logic [16*VDNUM-1:0] sd_buff_din,
  output logic                sd_buff_wr,
  output logic [28:0]         mem_address,
  output logic [7:0]          mem_burstcount,
  output logic                mem_read,
  output logic                mem_write,
  output logic [63:0]         mem_writedata,
  output logic [7:0]          mem_byteenable,
  input  logic                mem_waitrequest,
  input  logic [63:0]         mem_readdata,
  input  logic                mem_readdatavalid
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_RD_REQ, S_RD_WAIT,
    S_RD_OUT, S_WR_IN, S_WR_REQ, S_DONE
  } state_t;

  state_t             r_state, w_next;
  logic [1:0]         r_drive, w_sel;
  logic               w_any, w_sel_rd;
  logic [31:0]        r_lba, w_lba;
  logic               r_rd, r_oor;
  logic [5:0]         r_k;
  logic [2:0]         r_i;
  logic [1:0]         w_wi;
  logic [63:0]        r_data, r_wdata;
  logic [VDNUM-1:0]   r_ack;
  logic [28:0]        w_addr;
  logic [15:0]        w_din;

`ifdef SDRESP_BURST_EN
  logic [63:0] r_buf [64];
  logic [6:0]  r_wptr;
  logic        w_have, w_beat_in;

  assign w_have    = r_wptr > {1'b0, r_k};
  assign w_beat_in = mem_readdatavalid && r_rd &&
                     (r_state != S_IDLE) && !r_wptr[6];

  // Burst write pointer, rewound for every accepted request
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      r_wptr <= '0;
    else if (r_state == S_ACCEPT)
      r_wptr <= '0;
    else if (w_beat_in)
      r_wptr <= r_wptr + 7'd1;
  end

  // Burst beat storage, drained one beat per RD_OUT pass
  always_ff @(posedge clk_sys) begin
    if (w_beat_in)
      r_buf[r_wptr[5:0]] <= mem_readdata;
  end
`endif

  // Lowest-index requesting drive wins; read beats write on the same drive
  always_comb begin
    w_any    = 1'b0;
    w_sel    = '0;
    w_sel_rd = 1'b0;
    for (int d = VDNUM - 1; d >= 0; d--) begin
      if (sd_rd[d] | sd_wr[d]) begin
        w_any    = 1'b1;
        w_sel    = 2'(d);
        w_sel_rd = sd_rd[d];
      end
    end
  end

  assign w_lba  = sd_lba[{w_sel, 5'b0} +: 32];
  assign w_din  = sd_buff_din[{r_drive, 4'b0} +: 16];
  assign w_wi   = r_i[1:0] - 2'd1;
  assign w_addr = 29'(IMG_BASE >> 3)
                + 29'(r_drive) * 29'(IMG_STRIDE >> 3)
                + {r_lba[22:0], 6'b0}
                + 29'(r_k);

  assign sd_ack         = r_ack;
  assign mem_writedata  = r_wdata;
  assign mem_byteenable = 8'hFF;
  assign mem_address    = (mem_read | mem_write) ? w_addr : '0;
`ifdef SDRESP_BURST_EN
  assign mem_burstcount = mem_read ? 8'd64 : 8'd1;
`else
  assign mem_burstcount = 8'd1;
`endif

  // State register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next state and handshake outputs
  always_comb begin
    w_next       = r_state;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    sd_buff_wr   = 1'b0;
    sd_buff_addr = '0;
    sd_buff_dout = '0;
    unique case (r_state)
      S_IDLE:
        if (w_any) w_next = S_ACCEPT;
      S_ACCEPT:
        w_next = r_rd ? S_RD_REQ : S_WR_IN;
      S_RD_REQ:
        if (r_oor) w_next = S_RD_OUT;
`ifdef SDRESP_BURST_EN
        else if (r_k != 6'd0) w_next = S_RD_WAIT;
`endif
        else begin
          mem_read = 1'b1;
          if (!mem_waitrequest) w_next = S_RD_WAIT;
        end
      S_RD_WAIT:
`ifdef SDRESP_BURST_EN
        if (w_have) w_next = S_RD_OUT;
`else
        if (mem_readdatavalid) w_next = S_RD_OUT;
`endif
      S_RD_OUT: begin
        sd_buff_wr   = 1'b1;
        sd_buff_addr = {r_k, r_i[1:0]};
        sd_buff_dout = r_data[{r_i[1:0], 4'b0} +: 16];
        if (r_i == 3'd3)
          w_next = (r_k == 6'd63) ? S_DONE : S_RD_REQ;
      end
      S_WR_IN: begin
        sd_buff_addr = {r_k, (r_i == 3'd4) ? 2'd3 : r_i[1:0]};
        if (r_i == 3'd4) w_next = S_WR_REQ;
      end
      S_WR_REQ: begin
        mem_write = !r_oor;
        if (r_oor || !mem_waitrequest)
          w_next = (r_k == 6'd63) ? S_DONE : S_WR_IN;
      end
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Request latch, beat counters and data assembly
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_drive <= '0;
      r_lba   <= '0;
      r_rd    <= 1'b0;
      r_oor   <= 1'b0;
      r_k     <= '0;
      r_i     <= '0;
      r_data  <= '0;
      r_wdata <= '0;
      r_ack   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (w_any) begin
            r_drive <= w_sel;
            r_lba   <= w_lba;
            r_rd    <= w_sel_rd;
          end
        S_ACCEPT: begin
          r_ack <= VDNUM'(1) << r_drive;
          r_oor <= r_lba >= 32'(IMG_SECTORS);
          r_k   <= '0;
          r_i   <= '0;
        end
        S_RD_REQ:
          if (r_oor) r_data <= '0;
        S_RD_WAIT:
`ifdef SDRESP_BURST_EN
          if (w_have) r_data <= r_buf[r_k];
`else
          if (mem_readdatavalid) r_data <= mem_readdata;
`endif
        S_RD_OUT: begin
          r_i <= (r_i == 3'd3) ? 3'd0 : r_i + 3'd1;
          if (r_i == 3'd3) r_k <= r_k + 6'd1;
        end
        S_WR_IN: begin
          if (r_i != 3'd0) r_wdata[{w_wi, 4'b0} +: 16] <= w_din;
          r_i <= (r_i == 3'd4) ? 3'd0 : r_i + 3'd1;
        end
        S_WR_REQ:
          if (r_oor || !mem_waitrequest) r_k <= r_k + 6'd1;
        default: ;
      endcase
      if (w_next == S_DONE) r_ack <= '0;
    end
  end

endmodule

// File: doc/sd_sector_responder.md
Name: sd_sector_responder

Overview:
- Responder (storage-side) end of the virtual-disk sector interface: drives `sd_ack`, streams `sd_buff_addr`/`sd_buff_dout`/`sd_buff_wr`, samples `sd_buff_din`.
- Serves 512-byte sector read/write requests from up to VDNUM drives, using disk images held in DDR3 through a 64-bit Avalon-MM master.
- Used as a RAM-disk / simulation stand-in for the HPS side of the sector protocol in the SparcStation build.

Parameters:
- VDNUM, 3, number of drives (1..4).
- IMG_BASE, 32'h30000000, byte address of drive 0's image; must be 8-byte aligned.
- IMG_STRIDE, 32'h04000000, byte spacing between drive images.
- IMG_SECTORS, 131072, sectors per image; an LBA at or above this is out of range.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sd_lba  in  32*VDNUM  per-drive LBA; drive d is bits [32d+31:32d]
- sd_rd  in  VDNUM  per-drive read request (level)
- sd_wr  in  VDNUM  per-drive write request (level)
- sd_ack  out  VDNUM  per-drive acknowledge
- sd_buff_addr  out  8  16-bit word index within the sector
- sd_buff_dout  out  16  read data toward the requester
- sd_buff_din  in  16*VDNUM  per-drive write data; valid 1 cycle after sd_buff_addr
- sd_buff_wr  out  1  sd_buff_dout strobe
- mem_address  out  29  64-bit word address
- mem_burstcount  out  8  burst length
- mem_read  out  1  Avalon read
- mem_write  out  1  Avalon write
- mem_writedata  out  64  write data
- mem_byteenable  out  8  byte enables; always 8'hFF
- mem_waitrequest  in  1  Avalon stall
- mem_readdata  in  64  read data
- mem_readdatavalid  in  1  read data valid

Behaviour:
- Reset values: all outputs 0, except mem_byteenable=8'hFF and mem_burstcount=1. FSM returns to IDLE.
- Reset mid-operation: reset is asynchronous and abandons any transfer. A mem_readdatavalid received in IDLE is ignored.
- States: IDLE, ACCEPT, RD_REQ, RD_WAIT, RD_OUT, WR_IN, WR_REQ, DONE.
- IDLE: select the lowest-index drive d with sd_rd[d]|sd_wr[d]. If both are set on d, read wins. Latch d, the LBA and the direction.
- ACCEPT: assert sd_ack[d]; it is held until DONE. Beat counter k=0.
- Out of range: when lba >= IMG_SECTORS, set an oor flag.
- Address: mem_address = (IMG_BASE>>3) + d*(IMG_STRIDE>>3) + lba*64 + k, truncated to 29 bits.
- RD_REQ: hold mem_read=1 until a cycle with mem_waitrequest=0, then go to RD_WAIT. With oor set, skip the memory access; data is 64'h0.
- RD_WAIT: capture mem_readdata on mem_readdatavalid.
- RD_OUT: 4 consecutive cycles, i=0..3:
  - sd_buff_addr=4k+i
  - sd_buff_dout=data[16i+15:16i]
  - sd_buff_wr=1
  - Then k++; k==64 goes to DONE, otherwise RD_REQ.
- WR_IN: drive sd_buff_addr=4k+i for i=0..3; sample sd_buff_din[d] one cycle later into word i. This takes 5 cycles per beat, with the address of the next word overlapped.
- WR_REQ: mem_write=1 with the assembled beat, held until mem_waitrequest=0. Then k++; k==64 goes to DONE, otherwise WR_IN. With oor set, no mem_write is issued; the buffer reads still occur.
- DONE: sd_ack=0 for 1 cycle, then IDLE.
- Requester rule: the requester must drop its request while sd_ack is high. A request still high in IDLE is a new request.
- Request changes after acceptance are ignored. Exactly one drive is acked at a time.

Optional Feature:
- SDRESP_BURST_EN defined: reads issue a single mem_read with mem_burstcount=64 at beat address k=0.
  - Up to 64 returned beats are stored in a 64x64 buffer as they arrive.
  - RD_OUT drains the buffer 4 words per beat, stalling when empty.
  - Memory-read latency is paid once per sector; sd_buff output order is unchanged.
- SDRESP_BURST_EN undefined: single-beat reads as described in Behaviour; no buffer is instantiated.

Test Plan:
- Read, drive 0, LBA 0, memory word 0 = 64'h4444_3333_2222_1111:
  - sd_ack[0] rises 1 cycle after ACCEPT entry.
  - Words 0..3 appear as 1111, 2222, 3333, 4444.
  - 256 sd_buff_wr pulses total, then sd_ack falls.
- Write, drive 2, LBA 5, din[k]=k:
  - 64 mem_write beats at (IMG_BASE>>3)+2*(IMG_STRIDE>>3)+320..383.
  - First writedata = 64'h0003_0002_0001_0000; byteenable=FF.
- Simultaneous sd_rd=3'b110 and sd_wr=3'b010: drive 1 read is served first, then drive 2 read; the drive 1 write is not performed.
- LBA = IMG_SECTORS on read: 256 zero words, no mem_read. Same LBA on write: 256 buffer address cycles, no mem_write.
- mem_waitrequest held high 10 cycles on beat 7: mem_read and mem_address stay stable; no duplicate beats are output.
- Reset asserted during RD_OUT of beat 30: all outputs clear immediately. A subsequent new request completes normally and ignores the stale readdatavalid.
